seg7_scan: RTL and testbench

- Multiplexed 7-segment display driver; consumes the slow scan clock from the board clock divider.
- Synchronizes the divider output into the `clk` domain and advances one digit per rising edge.
- Snapshots a hex value once per full scan and drives active-low anodes, segments and decimal point for the MIPS debug display (PC/register value).
- Scan rate is set entirely by the upstream divider.

---
 rtl/seg7_pkg.sv | 18 +
 rtl/hex_to_seg7.sv | 11 +
 rtl/seg7_scan.sv | 124 ++++++++++++
 tb/tb_seg7_scan.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// Shared definitions for the 7-segment display blocks: scan FSM states,
// the all-off segment pattern and the active-low hex glyph table {g,f,e,d,c,b,a}.
package seg7_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      BLANK = 2'd1,
      SHOW  = 2'd2
   } state_e;

   localparam logic [6:0] SEG_BLANK = 7'h7F;

   localparam logic [6:0] SEG_TABLE [16] = '{
      7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
      7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
   };

endpackage

// File: rtl/hex_to_seg7.sv
// Combinational hex nibble to active-low 7-segment pattern decoder.
module hex_to_seg7
   import seg7_pkg::*;
(
   input  logic [3:0] hex,
   output logic [6:0] seg_n
);

   assign seg_n = SEG_TABLE[hex];

endmodule

// File: rtl/seg7_scan.sv
// Multiplexed 7-segment scanner: advances one digit per rising edge of the
// divided scan clock, with an all-off blanking gap before each digit lights.
module seg7_scan
   import seg7_pkg::*;
#(
   parameter int DIGITS       = 8,
   parameter int BLANK_CYCLES = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  step_clk,
   input  logic                  en,
   input  logic                  lz_en,
   input  logic [4*DIGITS-1:0]   data_in,
   input  logic [DIGITS-1:0]     dp_mask,
   output logic [DIGITS-1:0]     an_n,
   output logic [6:0]            seg_n,
   output logic                  dp_n
);

   localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam int CW = (BLANK_CYCLES > 0) ? $clog2(BLANK_CYCLES + 1) : 1;
   localparam logic [IW-1:0]     IDX_LAST = IW'(DIGITS - 1);
   localparam logic [CW-1:0]     CNT_INIT = CW'(BLANK_CYCLES);
   localparam logic [DIGITS-1:0] AN_ONE   = {{(DIGITS-1){1'b0}}, 1'b1};

   logic [1:0]          sync_q, sync_d;
   logic                prev_q, prev_d;
   logic                adv_q, adv_d;
   state_e              state_q, state_d;
   logic [IW-1:0]       idx_q, idx_d;
   logic [CW-1:0]       cnt_q, cnt_d;
   logic [4*DIGITS-1:0] snap_q, snap_d;
   logic [DIGITS-1:0]   snap_dp_q, snap_dp_d;
   logic [DIGITS-1:0]   an_q, an_d;
   logic [6:0]          seg_q, seg_d;
   logic                dp_q, dp_d;
   logic [3:0]          nib_d;
   logic [6:0]          glyph_d;
   logic                suppress_d;

   // Synchronizer, edge detect and scan sequencing
   always_comb begin
      sync_d    = {sync_q[0], step_clk};
      prev_d    = sync_q[1];
      adv_d     = sync_q[1] & ~prev_q;
      state_d   = state_q;
      idx_d     = idx_q;
      cnt_d     = cnt_q;
      snap_d    = snap_q;
      snap_dp_d = snap_dp_q;
      if (adv_q) begin
         idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
         // Capture only on wrap so a scan never mixes two data words.
         if (idx_d == '0) begin
            snap_d    = data_in;
            snap_dp_d = dp_mask;
         end
         state_d = BLANK;
         cnt_d   = CNT_INIT;
      end else begin
         case (state_q)
            BLANK: begin
               if (cnt_q == '0) state_d = SHOW;
               else             cnt_d   = cnt_q - 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign nib_d = snap_d[{idx_d, 2'b00} +: 4];

   hex_to_seg7 u_dec (
      .hex   (nib_d),
      .seg_n (glyph_d)
   );

   // Output registers are loaded from next-state so they align with the FSM.
   always_comb begin
      suppress_d = lz_en && (idx_d != '0) && ((snap_d >> {idx_d, 2'b00}) == '0);
      an_d       = '1;
      seg_d      = SEG_BLANK;
      dp_d       = 1'b1;
      if (state_d == SHOW && !suppress_d) begin
         an_d  = ~(AN_ONE << idx_d);
         seg_d = glyph_d;
         dp_d  = ~snap_dp_d[idx_d];
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sync_q    <= '0;
         prev_q    <= 1'b0;
         adv_q     <= 1'b0;
         state_q   <= IDLE;
         idx_q     <= IDX_LAST;
         cnt_q     <= '0;
         snap_q    <= '0;
         snap_dp_q <= '0;
         an_q      <= '1;
         seg_q     <= SEG_BLANK;
         dp_q      <= 1'b1;
      end else begin
         sync_q    <= sync_d;
         prev_q    <= prev_d;
         adv_q     <= adv_d;
         state_q   <= state_d;
         idx_q     <= idx_d;
         cnt_q     <= cnt_d;
         snap_q    <= snap_d;
         snap_dp_q <= snap_dp_d;
         an_q      <= an_d;
         seg_q     <= seg_d;
         dp_q      <= dp_d;
      end
   end

   assign an_n  = en ? an_q  : '1;
   assign seg_n = en ? seg_q : SEG_BLANK;
   assign dp_n  = en ? dp_q  : 1'b1;

endmodule

// File: tb/tb_seg7_scan.sv
// Bench for seg7_scan: scripted scenarios with literal expectations plus
// randomized scan-clock/data traffic checked every cycle against a behavioural model.
module tb_seg7_scan;

   localparam int DIGITS = 8;
   localparam int BLANK  = 2;

   localparam logic [6:0] SEG_REF [16] = '{
      7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
      7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
   };
   localparam logic [6:0] TEAR_SEG [5] = '{7'h12, 7'h19, 7'h30, 7'h24, 7'h79};

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        step_clk = 1'b0;
   logic        en = 1'b0;
   logic        lz_en = 1'b0;
   logic [31:0] data_in = 32'h0;
   logic [7:0]  dp_mask = 8'h0;
   logic [7:0]  an_n;
   logic [6:0]  seg_n;
   logic        dp_n;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   seg7_scan #(.DIGITS(DIGITS), .BLANK_CYCLES(BLANK)) dut (
      .clk      (clk),
      .rst      (rst),
      .step_clk (step_clk),
      .en       (en),
      .lz_en    (lz_en),
      .data_in  (data_in),
      .dp_mask  (dp_mask),
      .an_n     (an_n),
      .seg_n    (seg_n),
      .dp_n     (dp_n)
   );

   // Behavioural model: a rise of step_clk sampled at edge k advances the
   // scan at edge k+3; a digit lights after BLANK+1 cycles with no advance.
   int          m_idx   = DIGITS - 1;
   logic [31:0] m_snap  = 32'h0;
   logic [7:0]  m_dp    = 8'h0;
   bit          m_run   = 1'b0;
   int          m_since = 0;
   bit          m_lz    = 1'b0;
   logic [3:0]  m_hist  = 4'h0;

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         m_idx = DIGITS - 1; m_snap = 32'h0; m_dp = 8'h0;
         m_run = 1'b0; m_since = 0; m_lz = 1'b0; m_hist = 4'h0;
      end else begin
         if (m_hist[2] && !m_hist[3]) begin
            m_idx = (m_idx + 1) % DIGITS;
            if (m_idx == 0) begin
               m_snap = data_in;
               m_dp   = dp_mask;
            end
            m_run   = 1'b1;
            m_since = 0;
         end else if (m_since < 100000) begin
            m_since++;
         end
         m_hist = {m_hist[2:0], step_clk};
         m_lz   = lz_en;
      end
   end

   task automatic compare_model();
      logic [7:0] ean;
      logic [6:0] eseg;
      logic       edp;
      logic [3:0] nib;
      bit         lit, supp;
      nib  = 4'((m_snap >> (4 * m_idx)) & 32'hF);
      lit  = en && m_run && (m_since >= BLANK + 1);
      supp = m_lz && (m_idx != 0) && ((m_snap >> (4 * m_idx)) == 32'h0);
      ean  = 8'hFF; eseg = 7'h7F; edp = 1'b1;
      if (lit && !supp) begin
         ean  = ~(8'd1 << m_idx);
         eseg = SEG_REF[nib];
         edp  = ~m_dp[m_idx];
      end
      checks++;
      if (an_n !== ean || dp_n !== edp || (!(lit && supp) && seg_n !== eseg)) begin
         errors++;
         $display("FAIL model t=%0t: an_n=%h seg_n=%h dp_n=%b expected an_n=%h seg_n=%h dp_n=%b",
                  $time, an_n, seg_n, dp_n, ean, eseg, edp);
      end
   endtask

   task automatic check_out(input string name, input logic [7:0] ean,
                            input logic [6:0] eseg, input logic edp, input bit seg_chk);
      checks++;
      if (an_n !== ean || dp_n !== edp || (seg_chk && seg_n !== eseg)) begin
         errors++;
         $display("FAIL %s: an_n=%h seg_n=%h dp_n=%b expected an_n=%h seg_n=%h dp_n=%b",
                  name, an_n, seg_n, dp_n, ean, eseg, edp);
      end
   endtask

   // One step_clk rise; returns on the first falling clk edge after the new digit lights.
   task automatic advance();
      @(negedge clk); #1 step_clk = 1'b1;
      repeat (2) @(negedge clk);
      #1 step_clk = 1'b0;
      repeat (5) @(negedge clk);
   endtask

   initial begin
      fork
         forever begin
            @(negedge clk);
            compare_model();
         end
      join_none

      repeat (3) @(negedge clk);
      check_out("reset", 8'hFF, 7'h7F, 1'b1, 1'b1);
      #1 rst = 1'b1; data_in = 32'h12345678; en = 1'b1;
      advance();
      check_out("first_d0", 8'hFE, 7'h00, 1'b1, 1'b1);

      @(posedge clk); #2 rst = 1'b0;
      #1 check_out("async_reset", 8'hFF, 7'h7F, 1'b1, 1'b1);
      @(negedge clk); #1 rst = 1'b1;

      @(negedge clk); #1 step_clk = 1'b1;
      repeat (2) @(negedge clk);
      #1 step_clk = 1'b0;
      repeat (4) @(negedge clk);
      check_out("blank_last", 8'hFF, 7'h7F, 1'b1, 1'b1);
      @(negedge clk);
      check_out("show_d0", 8'hFE, 7'h00, 1'b1, 1'b1);
      advance();
      check_out("show_d1", 8'hFD, 7'h78, 1'b1, 1'b1);
      advance();
      check_out("show_d2", 8'hFB, 7'h02, 1'b1, 1'b1);
      #1 data_in = 32'hFFFF_FFFF;
      for (int i = 3; i < 8; i++) begin
         advance();
         check_out($sformatf("tear_d%0d", i), ~(8'd1 << i), TEAR_SEG[i-3], 1'b1, 1'b1);
      end
      advance();
      check_out("wrap_F", 8'hFE, 7'h0E, 1'b1, 1'b1);

      #1 data_in = 32'h0000_00A0; lz_en = 1'b1;
      repeat (7) advance();
      advance();
      check_out("lz_d0", 8'hFE, 7'h40, 1'b1, 1'b1);
      advance();
      check_out("lz_d1", 8'hFD, 7'h08, 1'b1, 1'b1);
      for (int i = 2; i < 8; i++) begin
         advance();
         check_out($sformatf("lz_sup_d%0d", i), 8'hFF, 7'h7F, 1'b1, 1'b0);
      end
      #1 data_in = 32'h0;
      advance();
      check_out("lz_zero_d0", 8'hFE, 7'h40, 1'b1, 1'b1);
      for (int i = 1; i < 8; i++) begin
         advance();
         check_out($sformatf("lz_zero_d%0d", i), 8'hFF, 7'h7F, 1'b1, 1'b0);
      end

      #1 lz_en = 1'b0; step_clk = 1'b1;
      repeat (1000) @(negedge clk);
      check_out("hold_one_adv", 8'hFE, 7'h40, 1'b1, 1'b1);
      #1 step_clk = 1'b0;
      repeat (3) @(negedge clk);
      #1 step_clk = 1'b1;
      @(negedge clk); #1 step_clk = 1'b0;
      @(negedge clk); #1 step_clk = 1'b1;
      @(negedge clk); #1 step_clk = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check_out("double_blank", 8'hFF, 7'h7F, 1'b1, 1'b1);
      end
      @(negedge clk);
      check_out("double_show_d2", 8'hFB, 7'h40, 1'b1, 1'b1);

      #1 dp_mask = 8'h01; data_in = 32'h12345678; en = 1'b0;
      for (int i = 0; i < 5; i++) begin
         advance();
         check_out("en_off", 8'hFF, 7'h7F, 1'b1, 1'b1);
      end
      #1 en = 1'b1;
      #1 check_out("en_back_d7", 8'h7F, 7'h40, 1'b1, 1'b1);
      advance();
      check_out("dp_d0", 8'hFE, 7'h00, 1'b0, 1'b1);
      advance();
      check_out("dp_d1", 8'hFD, 7'h78, 1'b1, 1'b1);

      repeat (4000) begin
         @(negedge clk); #1;
         if ($urandom_range(0, 7) == 0)   step_clk = ~step_clk;
         if ($urandom_range(0, 199) == 0) en = ~en;
         if ($urandom_range(0, 99) == 0)  lz_en = ~lz_en;
         if ($urandom_range(0, 49) == 0) begin
            data_in = $urandom >> (4 * $urandom_range(0, 8));
            dp_mask = 8'($urandom);
         end
      end

      @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
